dct_coef_reader: RTL and testbench
==================================

Name: dct_coef_reader

Overview:
- Read-side counterpart of the 2D-DCT write path: walks the 32768x80 coefficient SRAM after DCT completion and streams each 80-bit row word out on a valid/ready interface.
- Feeds the downstream consumer (IDCT or entropy coder) in raster block order, with row and block framing flags.
- Hides the 1-cycle SRAM read latency and absorbs consumer backpressure with a 2-entry buffer.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 80, SRAM word width (8 coefficients x COEF_W).
- COEF_W, 10, signed coefficient width.
- NUM_WORDS, 32768, words read per run.
- ROWS_PER_BLK, 8, rows per 8x8 block.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run when idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final handshake.
- mem_cen  out  1  SRAM chip enable, active-low.
- mem_wen  out  1  SRAM write enable, active-low; tied 1.
- mem_addr  out  ADDR_W  SRAM read address.
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_cen=0.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  coefficient row; coef k at bits [k*COEF_W +: COEF_W].
- out_sof  out  1  row 0 of a block.
- out_eob  out  1  row 7 of a block.
- out_last  out  1  final word of the run (address NUM_WORDS-1).
- checksum  out  DATA_W  running XOR of accepted words; see Optional Feature.

Behaviour:
- Reset values: busy=0, done=0, mem_cen=1, mem_wen=1, mem_addr=0, out_valid=0, out_data=0, all flags=0, checksum=0.
- Reset asserted mid-run aborts immediately. In-flight read data is discarded, the buffer is cleared, and the FSM returns to IDLE.
- States:
  - IDLE: start moves to READ and sets busy=1.
  - READ: issues reads while (in_flight + occupancy) < 2. Moves to DRAIN after address NUM_WORDS-1 is issued.
  - DRAIN: no reads issued; waits for the buffer to empty. Moves to DONE on the out_last handshake.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start in any state other than IDLE is ignored.
- Latency: start sampled at cycle T -> mem_cen=0, addr 0 at T+1 -> data captured into the buffer at T+2 -> out_valid=1 at T+3.
- Throughput: 1 word/cycle with out_ready held high. The last word is accepted at cycle T+2+NUM_WORDS.
- Handshake:
  - A transfer occurs when out_valid and out_ready are both high.
  - While out_valid=1 and out_ready=0: out_data and all flags are held stable, and out_valid does not drop.
- Buffer:
  - 2-entry FIFO; each entry carries data, sof, eob and last.
  - When full, no read is issued.
  - A simultaneous push and pop keeps occupancy unchanged.
  - A read is never issued if its data could not be stored.
- Flags are derived from the issued address: sof when addr[2:0]==0, eob when addr[2:0]==7, last when addr==NUM_WORDS-1.
- Address counter: increments by 1 per issued read; no wrap within a run; cleared to 0 at start.
- mem_addr holds its last value when mem_cen=1.

Optional Feature:
- Macro: DCT_READER_CHECKSUM_EN.
- Defined: checksum resets to 0 at start acceptance and XORs in out_data on every handshake; its final value is stable from done onward until the next start.
- Undefined: checksum is tied to 0 and no checksum registers are synthesized.

Decomposition:
- Shared package dct_mem_pkg:
  - Constants: ADDR_W, DATA_W, COEF_W, NUM_WORDS, ROWS_PER_BLK.
  - State enum: IDLE/READ/DRAIN/DONE.
  - Helper that extracts coefficient k from a row word.
- One sub-module, dct_coef_fifo2: 2-entry registered FIFO with push/pop/full/empty, DATA_W+3 bits wide.

Test Plan:
- SRAM preloaded with word i = i, out_ready=1, start at cycle 10 -> out_valid at cycle 13 with data 0, sof=1; 32768 consecutive words 0..32767; out_eob on every i%8==7; out_last on word 32767; done one cycle after.
- out_ready toggled 1,0,0,1 repeating -> every word delivered exactly once, in order, held stable while stalled; mem_cen never gives more than 2 outstanding plus buffered.
- out_ready=0 for 100 cycles after start -> exactly 2 reads issued (addr 0, 1); out_data holds 0; no further mem_cen=0 until the first pop.
- start pulsed again at cycle 500 mid-run -> ignored; address sequence and output stream unaffected.
- reset asserted at word 1000 for 1 cycle, then new start -> outputs at reset values, stream restarts from addr 0, no stale word emitted.
- With DCT_READER_CHECKSUM_EN, words = i -> checksum at done equals XOR of 0..32767 (=0); with preload word i = i*3+1, checksum matches the reference model value.

Source files
------------

// File: rtl/dct_mem_pkg.sv
// Shared definitions for the DCT coefficient SRAM read path.
// Provides the memory geometry constants, the reader FSM state type, the
// buffer entry layout and a helper that extracts one coefficient from a row.
package dct_mem_pkg;

    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned DATA_W       = 80;
    localparam int unsigned COEF_W       = 10;
    localparam int unsigned NUM_WORDS    = 32768;
    localparam int unsigned ROWS_PER_BLK = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One buffered row word together with its framing flags.
    typedef struct packed {
        logic              last;
        logic              eob;
        logic              sof;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Coefficient k of a row word lives at bits [k*COEF_W +: COEF_W].
    function automatic logic signed [COEF_W-1:0] get_coef(input logic [DATA_W-1:0] row,
                                                          input int unsigned       k);
        return row[k*COEF_W +: COEF_W];
    endfunction

endpackage

// File: rtl/dct_coef_fifo2.sv
// Two-entry registered FIFO used to absorb SRAM read latency and consumer
// backpressure in the coefficient reader.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears storage)
//   push_i, din_i   - write strobe and entry
//   pop_i           - read strobe (head is dropped at the clock edge)
//   dout_o          - current head entry
//   full_o, empty_o - occupancy status
// A push while full is accepted only together with a pop.
module dct_coef_fifo2 #(
    parameter int unsigned W = dct_mem_pkg::DATA_W + 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    import dct_mem_pkg::*;

    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) begin
                rptr_q <= ~rptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/dct_coef_reader.sv
// Streams the 2D-DCT coefficient SRAM out row by row after DCT completion.
// Each 80-bit row word is presented on a valid/ready interface in raster
// block order with sof (row 0), eob (row 7) and last (final address) flags.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start / busy / done   - run control: start pulse, run-in-progress, end pulse
//   mem_cen/wen/addr      - SRAM control (active-low; write enable tied high)
//   mem_rdata             - SRAM data, valid one cycle after mem_cen=0
//   out_valid / out_ready - output handshake
//   out_data              - coefficient row, coef k at [k*COEF_W +: COEF_W]
//   out_sof/eob/last      - framing flags for the presented word
//   checksum              - running XOR of accepted words
// Build option: DCT_READER_CHECKSUM_EN enables the checksum register;
// without it checksum is tied to zero.
module dct_coef_reader #(
    parameter int unsigned NUM_WORDS    = dct_mem_pkg::NUM_WORDS,
    parameter int unsigned ROWS_PER_BLK = dct_mem_pkg::ROWS_PER_BLK
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_cen,
    output logic                            mem_wen,
    output logic [dct_mem_pkg::ADDR_W-1:0]  mem_addr,
    input  logic [dct_mem_pkg::DATA_W-1:0]  mem_rdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [dct_mem_pkg::DATA_W-1:0]  out_data,
    output logic                            out_sof,
    output logic                            out_eob,
    output logic                            out_last,
    output logic [dct_mem_pkg::DATA_W-1:0]  checksum
);
    import dct_mem_pkg::*;

    localparam int unsigned       RB_W      = $clog2(ROWS_PER_BLK);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic              rvalid_q;
    logic              rsof_q;
    logic              reob_q;
    logic              rlast_q;

    logic              issue;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        occ;
    logic [2:0]        proj;
    entry_t            fifo_din;
    entry_t            fifo_dout;

    // A read issued now lands in the buffer two edges later. It is safe if the
    // buffer, after this cycle's pop and the already in-flight word, still has
    // a free slot assuming no further pops; counting this cycle's pop is what
    // sustains one word per cycle with out_ready held high.
    always_comb begin
        occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        proj  = {1'b0, occ} + {2'b00, rvalid_q} - {2'b00, pop};
        issue = (state_q == READ) && (proj < 3'd2);
    end

    assign pop      = out_valid && out_ready;
    assign mem_cen  = ~issue;
    assign mem_wen  = 1'b1;
    assign mem_addr = issue ? addr_q : addr_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            addr_hold_q <= '0;
            rvalid_q    <= 1'b0;
            rsof_q      <= 1'b0;
            reob_q      <= 1'b0;
            rlast_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= issue;
            if (issue) begin
                rsof_q      <= (addr_q[RB_W-1:0] == '0);
                reob_q      <= (addr_q[RB_W-1:0] == '1);
                rlast_q     <= (addr_q == LAST_ADDR);
                addr_q      <= addr_q + ADDR_W'(1);
                addr_hold_q <= addr_q;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                READ: begin
                    if (issue && (addr_q == LAST_ADDR)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && fifo_dout.last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_din = '{last: rlast_q, eob: reob_q, sof: rsof_q, data: mem_rdata};

    dct_coef_fifo2 #(
        .W($bits(entry_t))
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (rvalid_q),
        .din_i  (fifo_din),
        .pop_i  (pop),
        .dout_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_dout.data;
    assign out_sof   = out_valid & fifo_dout.sof;
    assign out_eob   = out_valid & fifo_dout.eob;
    assign out_last  = out_valid & fifo_dout.last;

`ifdef DCT_READER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    logic [DATA_W-1:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && start) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q ^ out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dct_coef_reader.sv
`timescale 1ns/1ps
module tb_dct_coef_reader;

    localparam int unsigned NW = 2048;
    localparam int unsigned AW = dct_mem_pkg::ADDR_W;
    localparam int unsigned DW = dct_mem_pkg::DATA_W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eob;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, mem_cen, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid, out_sof, out_eob, out_last;
    logic [DW-1:0] out_data, checksum;

    dct_coef_reader #(
        .NUM_WORDS   (NW),
        .ROWS_PER_BLK(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_cen  (mem_cen),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sof  (out_sof),
        .out_eob  (out_eob),
        .out_last (out_last),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, data valid one cycle after mem_cen=0.
    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) begin
        if (!mem_cen) mem_rdata <= sram[mem_addr];
    end

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int            issued, accepted, exp_addr, max_out, stall_err, addr_err, wen_err;
    int            first_cen_cyc, first_valid_cyc, last_acc_cyc, done_cyc;
    bit            done_seen, busy_at_done;
    logic [DW-1:0] ck_model, ck_at_done;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [2:0]    prev_flags;

    function automatic logic [DW-1:0] word(input bit mode, input int unsigned i);
        return mode ? DW'(i * 3 + 1) : DW'(i);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: pops expected words on every handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            issued     = 0;
            accepted   = 0;
            exp_addr   = 0;
            prev_stall = 1'b0;
        end else begin
            if (!mem_cen) begin
                if (first_cen_cyc < 0) first_cen_cyc = cyc;
                if (int'(mem_addr) != exp_addr) addr_err++;
                exp_addr++;
                issued++;
            end
            if (mem_wen !== 1'b1) wen_err++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!out_valid || out_data !== prev_data ||
                               {out_sof, out_eob, out_last} !== prev_flags)) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_flags = {out_sof, out_eob, out_last};
            if (out_valid && out_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h, expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("word data", out_data, e.data);
                    chk("word sof", DW'(out_sof), DW'(e.sof));
                    chk("word eob", DW'(out_eob), DW'(e.eob));
                    chk("word last", DW'(out_last), DW'(e.last));
                    ck_model = ck_model ^ e.data;
                    if (e.last) last_acc_cyc = cyc;
                end
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (done && !done_seen) begin
                done_seen    = 1'b1;
                done_cyc     = cyc;
                busy_at_done = busy;
                ck_at_done   = checksum;
            end
        end
    end

    task automatic load(input bit mode);
        for (int unsigned i = 0; i < NW; i++) sram[i] = word(mode, i);
    endtask

    task automatic reset_checks(input string name);
        chk({name, " busy"}, DW'(busy), '0);
        chk({name, " done"}, DW'(done), '0);
        chk({name, " mem_cen"}, DW'(mem_cen), DW'(1));
        chk({name, " mem_wen"}, DW'(mem_wen), DW'(1));
        chk({name, " mem_addr"}, DW'(mem_addr), '0);
        chk({name, " out_valid"}, DW'(out_valid), '0);
        chk({name, " out_data"}, out_data, '0);
        chk({name, " flags"}, DW'({out_sof, out_eob, out_last}), '0);
        chk({name, " checksum"}, checksum, '0);
    endtask

    // Called at posedge+1; start is sampled at the next edge.
    task automatic do_start(input bit mode, output int t);
        issued = 0; accepted = 0; exp_addr = 0; max_out = 0;
        stall_err = 0; addr_err = 0; wen_err = 0;
        first_cen_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
        done_seen = 1'b0; ck_model = '0;
        exp_q.delete();
        for (int unsigned i = 0; i < NW; i++)
            exp_q.push_back('{data: word(mode, i), sof: (i % 8 == 0), eob: (i % 8 == 7), last: (i == NW - 1)});
        t = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy after start", DW'(busy), DW'(1));
        chk("mem_cen after start", DW'(mem_cen), '0);
        chk("mem_addr after start", DW'(mem_addr), '0);
    endtask

    task automatic wait_done(input bit toggle, input int pulse_at, input int budget);
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        while (!done_seen && k < budget) begin
            out_ready = toggle ? pat[k % 4] : 1'b1;
            start = (cyc == pulse_at);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", budget);
        end
    endtask

    task automatic end_checks(input string name);
        logic [DW-1:0] exp_ck;
`ifdef DCT_READER_CHECKSUM_EN
        exp_ck = ck_model;
`else
        exp_ck = '0;
`endif
        chk_int({name, " words left in queue"}, exp_q.size(), 0);
        chk_int({name, " words accepted"}, accepted, NW);
        chk_int({name, " reads issued"}, issued, NW);
        chk_int({name, " address sequence errors"}, addr_err, 0);
        chk_int({name, " stall hold errors"}, stall_err, 0);
        chk_int({name, " mem_wen errors"}, wen_err, 0);
        chk({name, " busy at done"}, DW'(busy_at_done), '0);
        chk({name, " checksum at done"}, ck_at_done, exp_ck);
        repeat (3) @(posedge clk);
        #1;
        chk({name, " checksum idle"}, checksum, exp_ck);
        checks++;
        if (max_out > 2) begin
            errors++;
            $display("FAIL %s outstanding: got %0d, expected at most 2", name, max_out);
        end
    endtask

    task automatic timing_checks(input string name, input int t);
        chk_int({name, " first read cycle"}, first_cen_cyc, t + 1);
        chk_int({name, " first valid cycle"}, first_valid_cyc, t + 3);
        chk_int({name, " last accept cycle"}, last_acc_cyc, t + 2 + NW);
        chk_int({name, " done cycle"}, done_cyc, t + 3 + NW);
    endtask

    initial begin : stim
        int t;
        int k;
        first_cen_cyc = -1; first_valid_cyc = -1; ck_model = '0;
        issued = 0; accepted = 0; exp_addr = 0; max_out = 0;
        stall_err = 0; addr_err = 0; wen_err = 0; done_seen = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset_checks("reset");

        // Run A: word i = i, ready high, stray start at cycle 500.
        load(1'b0);
        out_ready = 1'b1;
        while (cyc < 10) begin @(posedge clk); #1; end
        do_start(1'b0, t);
        wait_done(1'b0, 500, NW + 200);
        timing_checks("runA", t);
        end_checks("runA");

        // Run B: word i = 3i+1, consumer stalled 100 cycles, then 1,0,0,1.
        load(1'b1);
        out_ready = 1'b0;
        do_start(1'b1, t);
        repeat (99) @(posedge clk);
        #1;
        chk_int("stall reads issued", issued, 2);
        chk_int("stall next address", exp_addr, 2);
        chk("stall mem_cen", DW'(mem_cen), DW'(1));
        chk("stall out_valid", DW'(out_valid), DW'(1));
        chk("stall out_data", out_data, DW'(1));
        chk("stall out_sof", DW'(out_sof), DW'(1));
        chk("stall coef0", DW'(dct_mem_pkg::get_coef(out_data, 0)), DW'(1));
        chk("stall coef1", DW'(dct_mem_pkg::get_coef(out_data, 1)), '0);
        wait_done(1'b1, -1, 4 * NW + 200);
        end_checks("runB");

        // Run C: abort with reset after 1000 words, then a clean restart.
        load(1'b0);
        out_ready = 1'b1;
        do_start(1'b0, t);
        k = 0;
        while (accepted < 1000 && k < 5000) begin @(posedge clk); #1; k++; end
        chk_int("abort reached word 1000", int'(accepted >= 1000), 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        reset_checks("abort");
        repeat (5) @(posedge clk);
        #1;
        chk_int("reads after abort", issued, 0);
        chk_int("words after abort", accepted, 0);
        do_start(1'b0, t);
        wait_done(1'b0, -1, NW + 200);
        timing_checks("runC", t);
        end_checks("runC");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
